// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the configurable serial pattern detector.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Low 'len' bits set; callers slice to their history width.
    function automatic logic [31:0] len_mask(input int len);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_shift_matcher.sv
// History shift register, fill counter and length-masked compare.
module seq_shift_matcher
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift,
    input  logic               clear,
    input  logic               x_bit,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic               overlap,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_n;

    assign mask   = MAX_LEN'(len_mask(int'(len)));
    assign hist_n = {hist_q[MAX_LEN-2:0], x_bit};
    assign fill_n = (fill_q == len) ? fill_q : fill_q + 1'b1;

    // Compare against the post-shift view so the hit lines up with the sample edge.
    assign hit = shift
              && (fill_n == len)
              && ((hist_n & mask) == (pattern & mask));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift) begin
            hist_q <= hist_n;
            fill_q <= (hit && !overlap) ? '0 : fill_n;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time configurable serial pattern detector: config, arm/disarm, match counting.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               X,
    input  logic               x_valid,
    output logic               Z1,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    state_t state_q;
    state_t state_n;

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   target_q;

    logic               cfg_legal;
    logic               shift;
    logic               clear;
    logic               hit;
    logic               err_n;
    logic [CNT_W-1:0]   cnt_inc;

    assign cfg_legal = (len_q != '0)
                    && (len_q <= LEN_W'(MAX_LEN))
                    && (target_q != '0);
    assign cnt_inc   = match_count + 1'b1;

    seq_shift_matcher #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .clk     (clk),
        .rst     (rst),
        .shift   (shift),
        .clear   (clear),
        .x_bit   (X),
        .len     (len_q),
        .pattern (pattern_q),
        .overlap (overlap_q),
        .hit     (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    // Abort wins over start and over any bit sampled in the same cycle.
    always_comb begin
        state_n = state_q;
        shift   = 1'b0;
        clear   = 1'b0;
        err_n   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!cfg_we && start && !abort) begin
                    if (cfg_legal) begin
                        state_n = HUNT;
                        clear   = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            HUNT: begin
                err_n = cfg_we;
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    shift = x_valid;
                    if (hit && (cnt_inc == target_q)) state_n = DONE;
                end
            end
            DONE: begin
                err_n = cfg_we;
                if (abort) begin
                    state_n = IDLE;
                end else if (start) begin
                    state_n = HUNT;
                    clear   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q   <= '0;
            len_q       <= '0;
            overlap_q   <= 1'b0;
            target_q    <= '0;
            match_count <= '0;
            Z1          <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            Z1      <= hit;
            cfg_err <= err_n;
            if (state_q == IDLE && cfg_we) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
                target_q  <= cfg_target;
            end
            if (clear)    match_count <= '0;
            else if (hit) match_count <= cnt_inc;
        end
    end

    assign busy = (state_q == HUNT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: directed scenarios plus random traffic.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               abort;
    logic               X;
    logic               x_valid;
    logic               Z1;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;
    logic               cfg_err;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W),
        .LEN_W   (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .X           (X),
        .x_valid     (x_valid),
        .Z1          (Z1),
        .match_count (match_count),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    typedef struct {
        bit z1;
        bit busy;
        bit done;
        bit err;
        int cnt;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   z1_seen = 0;
    int   err_seen = 0;

    // shadow config driven onto the ports on every cycle
    bit [7:0] s_pat = 0;
    bit [3:0] s_len = 0;
    bit       s_ov = 0;
    bit [7:0] s_tgt = 0;

    // reference model: mode 0 idle, 1 hunting, 2 done
    int       m_mode = 0;
    bit [7:0] m_pat = 0;
    int       m_len = 0;
    bit       m_ov = 0;
    int       m_tgt = 0;
    int       m_cnt = 0;
    bit       m_bits[$];

    task automatic chk(input string n, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", n, got, want, $time);
        end
    endtask

    function automatic bit m_match();
        int sz;
        sz = m_bits.size();
        if (sz < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (m_bits[sz - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive(input bit r, input bit we, input bit st,
                         input bit ab, input bit xv, input bit x);
        exp_t e;
        @(negedge clk);
        rst         = r;
        cfg_we      = we;
        cfg_pattern = s_pat;
        cfg_len     = s_len;
        cfg_overlap = s_ov;
        cfg_target  = s_tgt;
        start       = st;
        abort       = ab;
        x_valid     = xv;
        X           = x;
        e.z1  = 0;
        e.err = 0;
        if (r) begin
            m_mode = 0; m_pat = 0; m_len = 0; m_ov = 0;
            m_tgt = 0; m_cnt = 0; m_bits.delete();
        end else begin
            case (m_mode)
                0: begin
                    if (we) begin
                        m_pat = s_pat; m_len = s_len;
                        m_ov = s_ov;   m_tgt = s_tgt;
                    end else if (st && !ab) begin
                        if (m_len >= 1 && m_len <= MAX_LEN && m_tgt >= 1) begin
                            m_mode = 1; m_cnt = 0; m_bits.delete();
                        end else begin
                            e.err = 1;
                        end
                    end
                end
                1: begin
                    e.err = we;
                    if (ab) begin
                        m_mode = 0;
                    end else if (xv) begin
                        m_bits.push_back(x);
                        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
                        if (m_match()) begin
                            e.z1 = 1;
                            m_cnt++;
                            if (!m_ov) m_bits.delete();
                            if (m_cnt == m_tgt) m_mode = 2;
                        end
                    end
                end
                default: begin
                    e.err = we;
                    if (ab) m_mode = 0;
                    else if (st) begin
                        m_mode = 1; m_cnt = 0; m_bits.delete();
                    end
                end
            endcase
        end
        e.busy = (m_mode == 1);
        e.done = (m_mode == 2);
        e.cnt  = m_cnt;
        expq.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic go();
        drive(0, 0, 1, 0, 0, 0);
    endtask

    task automatic cfgw(input bit [7:0] p, input bit [3:0] l,
                        input bit o, input bit [7:0] t);
        s_pat = p; s_len = l; s_ov = o; s_tgt = t;
        drive(0, 1, 0, 0, 0, 0);
    endtask

    // first bit sent is v[n-1]; gap inserts an invalid cycle after each bit
    task automatic send(input bit [15:0] v, input int n, input bit gap);
        for (int i = n - 1; i >= 0; i--) begin
            drive(0, 0, 0, 0, 1, v[i]);
            if (gap) drive(0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        z1_seen  += int'(Z1);
        err_seen += int'(cfg_err);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("z1",    int'(Z1),      int'(e.z1));
            chk("busy",  int'(busy),    int'(e.busy));
            chk("done",  int'(done),    int'(e.done));
            chk("err",   int'(cfg_err), int'(e.err));
            chk("count", int'(match_count), e.cnt);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    localparam bit [15:0] STREAM = 16'b0010110110011101;

    initial begin
        rst = 1; cfg_we = 0; cfg_pattern = 0; cfg_len = 0;
        cfg_overlap = 0; cfg_target = 0; start = 0; abort = 0;
        X = 0; x_valid = 0;
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 1, 1);
        idle();
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(match_count), 0);

        // T1 overlap
        cfgw(8'b1011, 4, 1, 2);
        go();
        z1_seen = 0;
        send(STREAM, 14, 0);
        idle();
        chk("t1_z1s", z1_seen, 2);
        chk("t1_done", int'(done), 1);
        chk("t1_count", int'(match_count), 2);

        // T2 non-overlap
        drive(0, 0, 0, 1, 0, 0);
        cfgw(8'b1011, 4, 0, 3);
        go();
        z1_seen = 0;
        send(STREAM, 14, 0);
        idle();
        chk("t2_z1s", z1_seen, 1);
        chk("t2_count", int'(match_count), 1);
        chk("t2_busy", int'(busy), 1);

        // T3 gapped
        drive(0, 0, 0, 1, 0, 0);
        cfgw(8'b1011, 4, 1, 2);
        go();
        z1_seen = 0;
        send(STREAM, 14, 1);
        idle();
        chk("t3_z1s", z1_seen, 2);
        chk("t3_done", int'(done), 1);

        // T4 illegal configs and write while busy
        drive(0, 0, 0, 1, 0, 0);
        err_seen = 0;
        cfgw(8'b1, 0, 0, 1);
        go();
        idle();
        chk("t4a_busy", int'(busy), 0);
        cfgw(8'hff, 9, 0, 0);
        go();
        idle();
        chk("t4b_busy", int'(busy), 0);
        cfgw(8'b11, 2, 0, 1);
        go();
        cfgw(8'b1, 1, 0, 1);
        idle();
        chk("t4_errs", err_seen, 3);
        send(16'b0111, 4, 0);
        idle();
        chk("t4c_cfg_kept", int'(done), 1);

        // T5 abort, restart, reset
        drive(0, 0, 0, 1, 0, 0);
        cfgw(8'b1011, 4, 1, 2);
        go();
        send(16'b1011, 4, 0);
        drive(0, 0, 0, 1, 0, 0);
        idle();
        chk("t5_abort_busy", int'(busy), 0);
        chk("t5_abort_count", int'(match_count), 1);
        drive(0, 0, 1, 1, 0, 0);
        idle();
        chk("t5_startabort", int'(busy), 0);
        go();
        send(16'b1011011, 7, 0);
        idle();
        chk("t5_done", int'(done), 1);
        go();
        idle();
        chk("t5_restart_cnt", int'(match_count), 0);
        chk("t5_restart_busy", int'(busy), 1);
        send(16'b1011, 4, 0);
        drive(1, 0, 0, 0, 1, 1);
        idle();
        chk("t5_rst_count", int'(match_count), 0);
        chk("t5_rst_busy", int'(busy), 0);

        // T6 length-1
        cfgw(8'b1, 1, 0, 3);
        go();
        z1_seen = 0;
        send(16'b1101, 4, 0);
        idle();
        chk("t6_z1s", z1_seen, 3);
        chk("t6_done", int'(done), 1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bit r, we, st, ab, xv, x;
            r  = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 19) == 0);
            if (we) begin
                s_pat = 8'($urandom);
                s_len = 4'($urandom_range(0, 9));
                s_ov  = 1'($urandom_range(0, 1));
                s_tgt = 8'($urandom_range(0, 5));
            end
            st = ($urandom_range(0, 14) == 0);
            ab = ($urandom_range(0, 39) == 0);
            xv = ($urandom_range(0, 9) < 7);
            x  = 1'($urandom_range(0, 1));
            drive(r, we, st, ab, xv, x);
        end

        idle();
        idle();
        @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
